text_cell_fetcher: RTL and testbench
====================================

Name: text_cell_fetcher

Overview:
Downstream consumer of the text screen RAM read-only port A. On each scanline start it reads one row of COLUMNS cells (16-bit {attribute, code point} words) from the screen RAM. It streams them in column order over a valid/ready interface to the glyph renderer. An internal 2-entry skid buffer absorbs the RAM's 1-cycle read latency and renderer backpressure without losing or duplicating cells.

Parameters:
COLUMNS, 80, cells per text row (1..127)
ROWS, 25, text rows per screen (1..31)
ADDR_WIDTH, 11, screen RAM word address width
BASE_ADDR, 0, RAM word address of cell (row 0, column 0)

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
lineStart  in  1  single-cycle pulse: begin fetching row textRow
textRow  in  5  text row index, sampled when lineStart=1
ramEnable  out  1  read strobe to screen RAM port A (enableA)
ramAddress  out  ADDR_WIDTH  word address to screen RAM port A (addressA)
ramData  in  16  screen RAM port A read data (dataOutA), valid the cycle after ramEnable
cellValid  out  1  cellData/cellColumn/cellLast are valid
cellReady  in  1  renderer accepts the cell when cellValid&cellReady
cellData  out  16  [15:8] attribute, [7:0] code point
cellColumn  out  7  column index of the presented cell
cellLast  out  1  presented cell is column COLUMNS-1
busy  out  1  a line fetch/stream is in progress

Behaviour:
- Reset (async, immediate): state IDLE, ramEnable=0, ramAddress=0, cellValid=0, cellData=0, cellColumn=0, cellLast=0, busy=0. Skid buffer empty, in-flight flag cleared.
- States: IDLE, FETCH, DRAIN.
- IDLE: on lineStart with textRow<ROWS -> latch rowBase=(BASE_ADDR+textRow*COLUMNS) mod 2^ADDR_WIDTH, readCol=0, outCol=0, go FETCH, busy=1. If textRow>=ROWS, lineStart is ignored: stay IDLE, no RAM read.
- FETCH: ramEnable=1 in any cycle where (buffer occupancy + in-flight reads) < 2. ramAddress=(rowBase+readCol) mod 2^ADDR_WIDTH, registered with ramEnable. readCol increments per issued read. After issuing readCol=COLUMNS-1 -> DRAIN.
- Read return: data captured into the skid buffer the cycle after ramEnable, tagged with its column.
- Latency: first cellValid 2 cycles after lineStart (address register + RAM read). With cellReady held 1, one cell per clock; the last cell appears COLUMNS+1 cycles after lineStart.
- Output handshake: cellValid/cellData/cellColumn/cellLast stable while cellValid=1 and cellReady=0. A transfer occurs on cellValid&cellReady; next buffered cell presented the following cycle, or cellValid drops.
- cellLast=1 only with cellColumn=COLUMNS-1.
- DRAIN: no reads; when the last cell transfers -> IDLE, busy=0 the next cycle.
- lineStart while busy (any state): abort. Flush skid buffer, discard any in-flight read return, cellValid=0 the next cycle, restart with the new textRow (or go IDLE if textRow>=ROWS). No cell of the aborted line may appear after the lineStart cycle.
- lineStart in the same cycle as the final transfer: that transfer completes, then the new line starts.
- Address wrap: rowBase+readCol wraps modulo 2^ADDR_WIDTH; no overflow flag.
- Buffer never overflows: read issue is gated by occupancy + in-flight count, so reads stop when 2 cells are outstanding.

Optional Feature:
Macro TEXT_FETCH_BLINK_EN.
- Defined: adds input port blinkPhase (1 bit). A cell whose attribute bit 7 =1 is presented with code point 8'h00 while blinkPhase=1, sampled at read capture; attribute passes unchanged.
- Undefined: no blinkPhase port; ramData passes to cellData unmodified.

Test Plan:
- Reset mid-stream: assert reset while cellValid=1 -> all outputs 0 immediately; a later lineStart row 0 streams cleanly from column 0.
- RAM preloaded with word = address; lineStart textRow=2, cellReady=1 -> ramAddress 160..239; cells 0x00A0..0x00EF on columns 0..79, one per clock; cellLast only on 0x00EF; busy drops after.
- Backpressure: toggle cellReady pseudo-randomly on row 24 -> exactly 80 cells, addresses 1920..1999 in order, no loss/duplicate; outputs held stable while stalled.
- Abort: lineStart row 3, then lineStart row 5 at column 10 -> no row-3 cell after abort; full row 5 (400..479) streams.
- Invalid row: lineStart textRow=25 when idle -> ramEnable stays 0, busy stays 0, no cellValid.
- With TEXT_FETCH_BLINK_EN: cell 0x8741, blinkPhase=1 -> cellData 0x8700; blinkPhase=0 -> 0x8741; cell 0x0741 unaffected.

Source files
------------

// File: rtl/text_cell_fetcher.sv
// Streams one text row of {attribute, code} cells from screen RAM port A to the glyph renderer.
// Optional `TEXT_FETCH_BLINK_EN adds blinkPhase: blinking cells (attribute bit 7) show code 8'h00.
module text_cell_fetcher #(
    parameter int unsigned COLUMNS    = 80,
    parameter int unsigned ROWS       = 25,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  lineStart,
    input  logic [4:0]            textRow,
    output logic                  ramEnable,
    output logic [ADDR_WIDTH-1:0] ramAddress,
    input  logic [15:0]           ramData,
    output logic                  cellValid,
    input  logic                  cellReady,
    output logic [15:0]           cellData,
    output logic [6:0]            cellColumn,
    output logic                  cellLast,
    output logic                  busy
`ifdef TEXT_FETCH_BLINK_EN
    ,
    input  logic                  blinkPhase
`endif
);

    localparam logic [6:0] LAST_COL = 7'(COLUMNS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [6:0]            read_col_q, read_col_d;
    logic [6:0]            ram_col_q, ram_col_d;
    logic                  ram_en_q, ram_en_d;
    logic [6:0]            ret_col_q, ret_col_d;
    logic                  ret_valid_q, ret_valid_d;
    logic [1:0]            occ_q, occ_d;
    logic [15:0]           buf_data_q [2];
    logic [15:0]           buf_data_d [2];
    logic [6:0]            buf_col_q [2];
    logic [6:0]            buf_col_d [2];

    logic [15:0]           ret_data;
    logic [15:0]           q_data [2];
    logic [6:0]            q_col [2];
    logic [1:0]            q_cnt;
    logic                  xfer;
    logic                  row_ok;
    logic [ADDR_WIDTH-1:0] start_base;

`ifdef TEXT_FETCH_BLINK_EN
    assign ret_data = (blinkPhase && ramData[15]) ? {ramData[15:8], 8'h00} : ramData;
`else
    assign ret_data = ramData;
`endif

    assign row_ok     = 32'(textRow) < ROWS;
    assign start_base = ADDR_WIDTH'(BASE_ADDR + COLUMNS * 32'(textRow));

    // Logical queue: buffered cells first, then the read returning this cycle.
    always_comb begin
        q_data[0] = buf_data_q[0];
        q_col[0]  = buf_col_q[0];
        q_data[1] = buf_data_q[1];
        q_col[1]  = buf_col_q[1];
        if (ret_valid_q) begin
            if (occ_q == 2'd0) begin
                q_data[0] = ret_data;
                q_col[0]  = ret_col_q;
            end else begin
                q_data[1] = ret_data;
                q_col[1]  = ret_col_q;
            end
        end
        q_cnt = occ_q + {1'b0, ret_valid_q};
    end

    assign cellValid  = (q_cnt != 2'd0);
    assign cellData   = cellValid ? q_data[0] : '0;
    assign cellColumn = cellValid ? q_col[0] : '0;
    assign cellLast   = cellValid && (q_col[0] == LAST_COL);
    assign xfer       = cellValid && cellReady;
    assign ramEnable  = ram_en_q;
    assign ramAddress = ram_addr_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        row_base_d  = row_base_q;
        ram_addr_d  = ram_addr_q;
        read_col_d  = read_col_q;
        ram_col_d   = ram_col_q;
        ram_en_d    = 1'b0;
        ret_valid_d = ram_en_q;
        ret_col_d   = ram_col_q;
        buf_data_d  = q_data;
        buf_col_d   = q_col;
        occ_d       = q_cnt;
        if (xfer) begin
            buf_data_d[0] = q_data[1];
            buf_col_d[0]  = q_col[1];
            occ_d         = q_cnt - 2'd1;
        end

        case (state_q)
            FETCH: begin
                // Cells after this edge plus the read already issued must leave room for one more.
                if ((occ_d + {1'b0, ram_en_q}) < 2'd2) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = row_base_q + ADDR_WIDTH'(read_col_q);
                    ram_col_d  = read_col_q;
                    read_col_d = read_col_q + 7'd1;
                    if (read_col_q == LAST_COL) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && q_col[0] == LAST_COL) state_d = IDLE;
            end
            default: ;
        endcase

        // A new line pre-empts everything; the return of any read from the old line is dropped.
        if (lineStart) begin
            occ_d       = 2'd0;
            ret_valid_d = 1'b0;
            if (row_ok) begin
                row_base_d = start_base;
                ram_en_d   = 1'b1;
                ram_addr_d = start_base;
                ram_col_d  = 7'd0;
                read_col_d = 7'd1;
                state_d    = (COLUMNS == 1) ? DRAIN : FETCH;
            end else begin
                ram_en_d = 1'b0;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_base_q  <= '0;
            ram_addr_q  <= '0;
            read_col_q  <= '0;
            ram_col_q   <= '0;
            ram_en_q    <= 1'b0;
            ret_col_q   <= '0;
            ret_valid_q <= 1'b0;
            occ_q       <= '0;
            buf_data_q  <= '{default: '0};
            buf_col_q   <= '{default: '0};
        end else begin
            state_q     <= state_d;
            row_base_q  <= row_base_d;
            ram_addr_q  <= ram_addr_d;
            read_col_q  <= read_col_d;
            ram_col_q   <= ram_col_d;
            ram_en_q    <= ram_en_d;
            ret_col_q   <= ret_col_d;
            ret_valid_q <= ret_valid_d;
            occ_q       <= occ_d;
            buf_data_q  <= buf_data_d;
            buf_col_q   <= buf_col_d;
        end
    end

endmodule

// File: tb/tb_text_cell_fetcher.sv
// Randomized bench for text_cell_fetcher: a queue model of each requested row checked every cycle.
module tb_text_cell_fetcher;

    localparam int COLS = 80;
    localparam int NROWS = 25;
    localparam int AW = 11;

    logic          clock = 1'b0;
    logic          reset;
    logic          lineStart;
    logic [4:0]    textRow;
    logic          ramEnable;
    logic [AW-1:0] ramAddress;
    logic [15:0]   ramData;
    logic          cellValid;
    logic          cellReady;
    logic [15:0]   cellData;
    logic [6:0]    cellColumn;
    logic          cellLast;
    logic          busy;
    logic          blinkPhase = 1'b0;

    always #5 clock = ~clock;

    text_cell_fetcher #(.COLUMNS(COLS), .ROWS(NROWS), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clock(clock), .reset(reset), .lineStart(lineStart), .textRow(textRow),
        .ramEnable(ramEnable), .ramAddress(ramAddress), .ramData(ramData),
        .cellValid(cellValid), .cellReady(cellReady), .cellData(cellData),
        .cellColumn(cellColumn), .cellLast(cellLast), .busy(busy)
`ifdef TEXT_FETCH_BLINK_EN
        , .blinkPhase(blinkPhase)
`endif
    );

    logic [15:0] mem [2048];
    logic [15:0] rd_q = '0;
    always @(posedge clock) if (ramEnable) rd_q <= mem[ramAddress];
    assign ramData = rd_q;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { logic [15:0] d; logic [6:0] c; } cell_t;
    cell_t       exp_q [$];
    logic        exp_busy = 1'b0;
    logic        rd_active = 1'b0;
    int          rd_base = 0;
    int          rd_col = 0;
    int          xfers = 0;
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [6:0]  prev_col;
    logic        prev_last;

    task automatic load_line(input int row);
        cell_t c;
        exp_q.delete();
        xfers = 0;
        if (row < NROWS) begin
            for (int col = 0; col < COLS; col++) begin
                c.d = mem[(row * COLS + col) % 2048];
`ifdef TEXT_FETCH_BLINK_EN
                if (blinkPhase && c.d[15]) c.d[7:0] = 8'h00;
`endif
                c.c = 7'(col);
                exp_q.push_back(c);
            end
            exp_busy  = 1'b1;
            rd_active = 1'b1;
            rd_col    = 0;
            rd_base   = row * COLS;
        end else begin
            exp_busy  = 1'b0;
            rd_active = 1'b0;
        end
    endtask

    always @(negedge clock) begin
        if (!reset && mon_en) begin
            chk("busy", busy, exp_busy);
            if (prev_stall) begin
                chk("hold_valid", cellValid, 1);
                chk("hold_data", cellData, prev_data);
                chk("hold_col", cellColumn, prev_col);
                chk("hold_last", cellLast, prev_last);
            end
            if (cellValid) begin
                if (exp_q.size() == 0) chk("spurious_cell", cellValid, 0);
                else begin
                    chk("cell_data", cellData, exp_q[0].d);
                    chk("cell_col", cellColumn, exp_q[0].c);
                    chk("cell_last", cellLast, exp_q[0].c == 7'(COLS - 1));
                    if (cellReady) begin
                        void'(exp_q.pop_front());
                        xfers++;
                        if (exp_q.size() == 0) exp_busy = 1'b0;
                    end
                end
            end
            if (ramEnable) begin
                chk("read_expected", rd_active, 1);
                if (rd_active) begin
                    chk("ram_addr", ramAddress, (rd_base + rd_col) % 2048);
                    rd_col++;
                    if (rd_col == COLS) rd_active = 1'b0;
                end
            end
            prev_stall = cellValid && !cellReady && !lineStart;
            prev_data  = cellData;
            prev_col   = cellColumn;
            prev_last  = cellLast;
            if (lineStart) load_line(int'(textRow));
        end
    end

    task automatic clear_model();
        exp_q.delete();
        exp_busy   = 1'b0;
        rd_active  = 1'b0;
        prev_stall = 1'b0;
    endtask

    // Called at #1 after a rising edge; pulses lineStart for one cycle.
    task automatic pulse(input int row);
        lineStart = 1'b1;
        textRow   = 5'(row);
        @(posedge clock); #1;
        lineStart = 1'b0;
    endtask

    // Runs a line to completion with optional random backpressure, a mid-line abort
    // at cycle abort_at, or a restart in the same cycle as the final transfer.
    task automatic run_line(input int row, input bit rnd, input int abort_at,
                            input int next_row, input bit at_last);
        int  cyc = 0;
        bit  done = 0;
        bit  pend_last = at_last;
        lineStart = 1'b1;
        textRow   = 5'(row);
        while (!done && cyc < 3000) begin
            @(posedge clock); #1;
            lineStart = 1'b0;
            cyc++;
            cellReady = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (cyc == abort_at) begin
                lineStart = 1'b1;
                textRow   = 5'(next_row);
            end
            if (pend_last && cellValid && cellLast && cellReady) begin
                lineStart = 1'b1;
                textRow   = 5'(next_row);
                pend_last = 0;
            end
            if (!lineStart && !busy && !cellValid) done = 1;
        end
        chk("line_timeout", done, 1);
        cellReady = 1'b1;
    endtask

    initial begin
        int c;
        reset = 1'b1; lineStart = 1'b0; textRow = '0; cellReady = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = 16'(i);
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", cellValid, 0);
        chk("rst_en", ramEnable, 0);
        chk("rst_addr", ramAddress, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clock); #1;

        // Row 2, free-flowing: pins latency and literal data
        pulse(2);
        @(negedge clock);
        chk("c1_en", ramEnable, 1);
        chk("c1_addr", ramAddress, 160);
        chk("c1_valid", cellValid, 0);
        @(negedge clock);
        chk("c2_valid", cellValid, 1);
        chk("c2_data", cellData, 16'h00A0);
        chk("c2_col", cellColumn, 0);
        c = 2;
        while (!(cellValid && cellLast) && c < 200) begin
            @(negedge clock);
            c++;
        end
        chk("last_latency", c, 81);
        chk("last_data", cellData, 16'h00EF);
        chk("last_col", cellColumn, 79);
        @(negedge clock);
        chk("busy_after", busy, 0);
        chk("row2_count", xfers, 80);
        @(posedge clock); #1;

        // Row 24 with backpressure
        run_line(24, 1, -1, 0, 0);
        chk("row24_count", xfers, 80);

        // Abort row 3 at column 10, restart row 5
        lineStart = 1'b1; textRow = 5'd3;
        c = 0;
        do begin
            @(posedge clock); #1;
            lineStart = 1'b0;
            c++;
        end while (!(cellValid && cellColumn == 7'd10) && c < 100);
        chk("abort_reached", cellColumn, 10);
        run_line(5, 0, -1, 0, 0);
        chk("row5_count", xfers, 80);

        // Invalid row while idle
        pulse(25);
        repeat (4) begin
            @(negedge clock);
            chk("inv_en", ramEnable, 0);
            chk("inv_busy", busy, 0);
            chk("inv_valid", cellValid, 0);
        end
        @(posedge clock); #1;

        // Restart in the same cycle as the final transfer
        run_line(4, 0, -1, 9, 1);
        chk("chain_count", xfers, 80);

        // Reset mid-stream
        cellReady = 1'b0;
        pulse(7);
        repeat (5) @(posedge clock);
        #1;
        chk("pre_rst_valid", cellValid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", cellValid, 0);
        chk("mid_rst_data", cellData, 0);
        chk("mid_rst_col", cellColumn, 0);
        chk("mid_rst_last", cellLast, 0);
        chk("mid_rst_en", ramEnable, 0);
        chk("mid_rst_addr", ramAddress, 0);
        chk("mid_rst_busy", busy, 0);
        clear_model();
        @(posedge clock); #1;
        reset = 1'b0;
        cellReady = 1'b1;
        @(posedge clock); #1;
        run_line(0, 1, -1, 0, 0);
        chk("post_rst_count", xfers, 80);

`ifdef TEXT_FETCH_BLINK_EN
        mem[6 * COLS]     = 16'h8741;
        mem[6 * COLS + 1] = 16'h0741;
        blinkPhase = 1'b1;
        pulse(6);
        @(negedge clock); @(negedge clock);
        chk("blink_on", cellData, 16'h8700);
        @(negedge clock);
        chk("blink_plain", cellData, 16'h0741);
        run_line(6, 0, -1, 0, 0);
        blinkPhase = 1'b0;
        pulse(6);
        @(negedge clock); @(negedge clock);
        chk("blink_off", cellData, 16'h8741);
        run_line(6, 0, -1, 0, 0);
`endif

        // Random lines, contents, backpressure and aborts
        for (int n = 0; n < 40; n++) begin
            int kind;
            for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
`ifdef TEXT_FETCH_BLINK_EN
            blinkPhase = 1'($urandom_range(0, 1));
`endif
            kind = $urandom_range(0, 3);
            if (kind == 0)
                run_line($urandom_range(0, 31), 1, $urandom_range(1, 120), $urandom_range(0, 31), 0);
            else if (kind == 1)
                run_line($urandom_range(0, 24), $urandom_range(0, 1), -1, $urandom_range(0, 24), 1);
            else
                run_line($urandom_range(0, 31), 1, -1, 0, 0);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock); #1;
            end
        end

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
